// File: rtl/watchdog_pkg.sv
// rtl/watchdog_pkg.sv - shared types and default constants for the activity watchdog
// Purpose: per-channel FSM state encoding and parameter defaults used by
//          watchdog_ch and watchdog_activity_mc.
// Ports:   none (package).
package watchdog_pkg;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_EXPIRED  = 2'd2
   } wdg_state_e;

   localparam int DEF_CH_NUM   = 4;
   localparam int DEF_CNT_W    = 31;
   localparam int DEF_FILT_LEN = 2;

endpackage

// File: rtl/watchdog_ch.sv
// rtl/watchdog_ch.sv - one watchdog channel: sync, glitch filter, edge detect, counter, FSM
// Purpose: watches one asynchronous activity line and flags a timeout when no
//          filtered edge is seen for timeout_val+1 armed cycles.
// Ports:   clk_25m/rst_n   work clock, async active-low reset
//          act_in          asynchronous activity line
//          wdg_enable      channel enable (clk_25m domain)
//          timeout_val     terminal count, 0 = never expire
//          flag_clr        one-cycle clear of the sticky flag (leaves EXPIRED)
//          timeout_flag    sticky timeout flag
//          timeout_pulse   one-cycle pulse on ARMED->EXPIRED
// Config:  WDG_AUTO_REARM_EN - when defined, an activity event also leaves EXPIRED.
module watchdog_ch
   import watchdog_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int FILT_LEN = DEF_FILT_LEN
) (
   input  logic             clk_25m,
   input  logic             rst_n,
   input  logic             act_in,
   input  logic             wdg_enable,
   input  logic [CNT_W-1:0] timeout_val,
   input  logic             flag_clr,
   output logic             timeout_flag,
   output logic             timeout_pulse
);

   // Filter accepts a new level once the mismatch count reaches FILT_LEN-1
   // and the mismatch persists one more cycle.
   localparam logic [3:0] STAB_LAST = 4'(FILT_LEN - 1);

   logic [1:0]       sync_q;
   logic             filt_q;
   logic             filt_d_q;
   logic [3:0]       stab_q;
   logic             act_ev;
   logic             rearm;

   wdg_state_e       state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             flag_q, flag_nxt;
   logic             pulse_q, pulse_nxt;

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         filt_q   <= 1'b0;
         filt_d_q <= 1'b0;
         stab_q   <= '0;
      end else begin
         sync_q   <= {sync_q[0], act_in};
         filt_d_q <= filt_q;
         if (sync_q[1] != filt_q) begin
            if (stab_q == STAB_LAST) begin
               filt_q <= sync_q[1];
               stab_q <= '0;
            end else begin
               stab_q <= stab_q + 4'd1;
            end
         end else begin
            stab_q <= '0;
         end
      end
   end

   // Event is seen the cycle after the filtered level changes.
   assign act_ev = filt_q ^ filt_d_q;

`ifdef WDG_AUTO_REARM_EN
   assign rearm = flag_clr | act_ev;
`else
   assign rearm = flag_clr;
`endif

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_DISABLED;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         flag_q  <= flag_nxt;
         pulse_q <= pulse_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      flag_nxt  = flag_q;
      pulse_nxt = 1'b0;
      if (!wdg_enable) begin
         state_nxt = ST_DISABLED;
         cnt_nxt   = '0;
         flag_nxt  = 1'b0;
      end else begin
         case (state_q)
            ST_DISABLED: begin
               state_nxt = ST_ARMED;
               cnt_nxt   = '0;
            end
            ST_ARMED: begin
               // Activity beats terminal count; flag_clr is ignored here so an
               // expiry in the same cycle still sets the flag.
               if (act_ev) begin
                  cnt_nxt = '0;
               end else if ((timeout_val != '0) && (cnt_q == timeout_val)) begin
                  state_nxt = ST_EXPIRED;
                  cnt_nxt   = '0;
                  flag_nxt  = 1'b1;
                  pulse_nxt = 1'b1;
               end else if (cnt_q != '1) begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
            ST_EXPIRED: begin
               cnt_nxt = '0;
               if (rearm) begin
                  state_nxt = ST_ARMED;
                  flag_nxt  = 1'b0;
               end
            end
            default: begin
               state_nxt = ST_DISABLED;
               cnt_nxt   = '0;
               flag_nxt  = 1'b0;
            end
         endcase
      end
   end

   assign timeout_flag  = flag_q;
   assign timeout_pulse = pulse_q;

endmodule

// File: rtl/watchdog_activity_mc.sv
// rtl/watchdog_activity_mc.sv - multi-channel activity watchdog top
// Purpose: CH_NUM independent watchdog_ch instances plus an any-timeout OR.
// Ports:   clk_25m/rst_n   work clock, async active-low reset
//          act_in          per-channel asynchronous activity lines
//          wdg_enable      per-channel enable
//          timeout_val     shared terminal count (quasi-static), 0 = never expire
//          flag_clr        per-channel sticky flag clear
//          timeout_flag    per-channel sticky flag
//          timeout_pulse   per-channel expiry pulse
//          timeout_any     OR of timeout_flag
// Config:  WDG_AUTO_REARM_EN - activity in EXPIRED re-arms the channel.
module watchdog_activity_mc
   import watchdog_pkg::*;
#(
   parameter int CH_NUM   = DEF_CH_NUM,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int FILT_LEN = DEF_FILT_LEN
) (
   input  logic              clk_25m,
   input  logic              rst_n,
   input  logic [CH_NUM-1:0] act_in,
   input  logic [CH_NUM-1:0] wdg_enable,
   input  logic [CNT_W-1:0]  timeout_val,
   input  logic [CH_NUM-1:0] flag_clr,
   output logic [CH_NUM-1:0] timeout_flag,
   output logic [CH_NUM-1:0] timeout_pulse,
   output logic              timeout_any
);

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      watchdog_ch #(
         .CNT_W    (CNT_W),
         .FILT_LEN (FILT_LEN)
      ) u_ch (
         .clk_25m       (clk_25m),
         .rst_n         (rst_n),
         .act_in        (act_in[g]),
         .wdg_enable    (wdg_enable[g]),
         .timeout_val   (timeout_val),
         .flag_clr      (flag_clr[g]),
         .timeout_flag  (timeout_flag[g]),
         .timeout_pulse (timeout_pulse[g])
      );
   end

   assign timeout_any = |timeout_flag;

endmodule

// File: tb/tb_watchdog_activity_mc.sv
// tb/tb_watchdog_activity_mc.sv - self-checking bench for watchdog_activity_mc
module tb_watchdog_activity_mc;

   localparam int CH   = 4;
   localparam int CW   = 31;
   localparam int FL   = 2;
   localparam int MAXC = 4096;

   logic          clk_25m = 1'b0;
   logic          rst_n;
   logic [CH-1:0] act_in;
   logic [CH-1:0] wdg_enable;
   logic [CW-1:0] timeout_val;
   logic [CH-1:0] flag_clr;
   logic [CH-1:0] timeout_flag;
   logic [CH-1:0] timeout_pulse;
   logic          timeout_any;

   always #20 clk_25m = ~clk_25m;

   watchdog_activity_mc #(
      .CH_NUM   (CH),
      .CNT_W    (CW),
      .FILT_LEN (FL)
   ) dut (
      .clk_25m       (clk_25m),
      .rst_n         (rst_n),
      .act_in        (act_in),
      .wdg_enable    (wdg_enable),
      .timeout_val   (timeout_val),
      .flag_clr      (flag_clr),
      .timeout_flag  (timeout_flag),
      .timeout_pulse (timeout_pulse),
      .timeout_any   (timeout_any)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Reference model: act_in history per cycle, filtered level, and the cycle
   // at which the channel's count was last at zero (arm timestamp).
   bit act_hist [CH][MAXC];
   int m_st     [CH];          // 0 off, 1 watching, 2 timed out
   int m_arm    [CH];
   bit m_flag   [CH];
   bit m_pulse  [CH];
   bit m_filt   [CH];
   bit m_filt_prev [CH];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit sync_at(input int ch, input int c);
      if (c - 2 < 0) return 1'b0;
      return act_hist[ch][c-2];
   endfunction

   task automatic check_model();
      logic [CH-1:0] ef, ep;
      for (int ch = 0; ch < CH; ch++) begin
         ef[ch] = m_flag[ch];
         ep[ch] = m_pulse[ch];
      end
      check_val("outputs", {timeout_any, timeout_flag, timeout_pulse}, {|ef, ef, ep});
   endtask

   task automatic model_step();
      for (int ch = 0; ch < CH; ch++) begin
         bit ev, all_diff, rearm;
         act_hist[ch][cyc] = act_in[ch];
         if (!rst_n) begin
            for (int k = 0; k < 3; k++)
               if (cyc - k >= 0) act_hist[ch][cyc-k] = 1'b0;
            m_st[ch] = 0; m_flag[ch] = 0; m_pulse[ch] = 0;
            m_filt[ch] = 0; m_filt_prev[ch] = 0;
         end else begin
            ev = (m_filt[ch] != m_filt_prev[ch]);
            all_diff = 1'b1;
            for (int j = 0; j < FL; j++)
               if (sync_at(ch, cyc - j) == m_filt[ch]) all_diff = 1'b0;
            m_filt_prev[ch] = m_filt[ch];
            if (all_diff) m_filt[ch] = ~m_filt[ch];
            m_pulse[ch] = 1'b0;
            if (!wdg_enable[ch]) begin
               m_st[ch] = 0;
               m_flag[ch] = 1'b0;
            end else if (m_st[ch] == 0) begin
               m_st[ch] = 1;
               m_arm[ch] = cyc + 1;
            end else if (m_st[ch] == 1) begin
               if (ev) m_arm[ch] = cyc + 1;
               else if (timeout_val != 0 && (cyc - m_arm[ch]) == int'(timeout_val)) begin
                  m_st[ch] = 2; m_flag[ch] = 1'b1; m_pulse[ch] = 1'b1;
               end
            end else begin
`ifdef WDG_AUTO_REARM_EN
               rearm = flag_clr[ch] | ev;
`else
               rearm = flag_clr[ch];
`endif
               if (rearm) begin
                  m_st[ch] = 1; m_arm[ch] = cyc + 1; m_flag[ch] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_25m);
      @(negedge clk_25m);
      cyc++;
      check_model();
   endtask

   initial begin
      int npul;
      bit lvl [CH];
      rst_n = 1'b0; act_in = '0; wdg_enable = '0; flag_clr = '0; timeout_val = CW'(10);
      @(negedge clk_25m);
      check_val("reset_flag", timeout_flag, 0);
      check_val("reset_pulse", timeout_pulse, 0);
      check_val("reset_any", timeout_any, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // Tests 1-3: ch0 idle, ch1 toggles every 8 cycles, ch2 sees a 1-cycle glitch.
      for (int rel = 0; rel < 40; rel++) begin
         wdg_enable = 4'b0111;
         if (rel % 8 == 2) act_in[1] = ~act_in[1];
         act_in[2] = (rel == 3);
         tick();
         if (rel + 1 == 11) check_val("t1_pulse_c11", timeout_pulse[0], 0);
         if (rel + 1 == 12) check_val("t1_pulse_c12", timeout_pulse[0], 1);
         if (rel + 1 == 13) check_val("t1_pulse_c13", timeout_pulse[0], 0);
         if (rel + 1 == 12) check_val("t3_glitch_pulse_c12", timeout_pulse[2], 1);
         check_val("t2_flag1_clear", timeout_flag[1], 0);
      end
      check_val("t1_flag_sticky", timeout_flag[0], 1);
      check_val("t1_any", timeout_any, 1);

      // Test 4: clear coincident with expiry, then one cycle later.
      wdg_enable = '0; act_in = '0;
      repeat (6) tick();
      for (int rel = 0; rel < 30; rel++) begin
         wdg_enable = 4'b0001;
         flag_clr   = (rel == 11 || rel == 12) ? 4'b0001 : 4'b0000;
         tick();
         if (rel + 1 == 12) check_val("t4_set_wins", {timeout_flag[0], timeout_pulse[0]}, 2'b11);
         if (rel + 1 == 13) check_val("t4_flag_cleared", timeout_flag[0], 0);
         if (rel + 1 == 23) check_val("t4_no_early_pulse", timeout_pulse[0], 0);
         if (rel + 1 == 24) check_val("t4_repulse", timeout_pulse[0], 1);
      end
      flag_clr = '0;

      // Test 5: activity edge while EXPIRED.
      for (int k = 0; k < 8; k++) begin
         act_in[0] = 1'b1;
         tick();
         if (k + 1 == 4) check_val("t5_flag_before", timeout_flag[0], 1);
`ifdef WDG_AUTO_REARM_EN
         if (k + 1 == 2 + FL + 1) check_val("t5_auto_rearm", timeout_flag[0], 0);
`else
         if (k + 1 == 2 + FL + 1) check_val("t5_no_rearm", timeout_flag[0], 1);
`endif
      end

      // Test 6: reset mid-count and in EXPIRED, then timeout_val = 0.
      wdg_enable = '0; act_in = '0;
      repeat (5) tick();
      wdg_enable = '1;
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_mid", {timeout_any, timeout_flag, timeout_pulse}, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int rel = 0; rel < 14; rel++) begin
         tick();
         if (rel + 1 == 12) check_val("t6_restart_pulse", timeout_pulse, 4'hF);
      end
      check_val("t6_flags_set", timeout_flag, 4'hF);
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_expired", {timeout_any, timeout_flag, timeout_pulse}, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      timeout_val = '0;
      npul = 0;
      repeat (150) begin
         tick();
         if (timeout_pulse != 0) npul++;
      end
      check_val("t6_tv0_no_pulse", npul, 0);

      // Randomised traffic.
      for (int ch = 0; ch < CH; ch++) lvl[ch] = act_in[ch];
      for (int i = 0; i < 1500; i++) begin
         if (i % 300 == 0) timeout_val = CW'($urandom_range(3, 15));
         for (int ch = 0; ch < CH; ch++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) lvl[ch] = ~lvl[ch];
            act_in[ch] = lvl[ch] ^ (r == 1);
            if ($urandom_range(0, 99) == 0) wdg_enable[ch] = ~wdg_enable[ch];
            flag_clr[ch] = ($urandom_range(0, 9) == 0);
         end
         rst_n = ($urandom_range(0, 499) != 0);
         if (!rst_n) begin
            #1;
            check_val("rnd_rst_immediate", {timeout_any, timeout_flag, timeout_pulse}, 0);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
